hazard_ctl_s23: RTL and testbench

HAZARD_CTL_S23 -- requirements
Module: hazard_ctl_s23

---
 rtl/hazard_ctl_s23_pkg.sv | 14 +
 rtl/hazard_ctl_s23_sat_cnt16.sv | 11 +
 rtl/hazard_ctl_s23.sv | 83 ++++++++
 tb/tb_hazard_ctl_s23.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/hazard_ctl_s23_pkg.sv
// hazard_ctl_s23_pkg: shared pipeline definitions (FSM encoding, NOP, register field positions)
package hazard_ctl_s23_pkg;
    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;
    localparam logic [31:0] NOP = 32'h00000013;
    function automatic logic [4:0] rs1_of(input logic [31:0] i);
        return i[19:15];
    endfunction
    function automatic logic [4:0] rs2_of(input logic [31:0] i);
        return i[24:20];
    endfunction
    function automatic logic [4:0] rd_of(input logic [31:0] i);
        return i[11:7];
    endfunction
endpackage

// File: rtl/hazard_ctl_s23_sat_cnt16.sv
// sat_cnt16: 16-bit event counter that sticks at all-ones, async active-low clear
module sat_cnt16 (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        en,
    output logic [15:0] cnt
);
    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) cnt <= '0;
        else if (en && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
endmodule

// File: rtl/hazard_ctl_s23.sv
// hazard_ctl_s23: pipeline hazard control (memory-wait stall with timeout, branch flush, forwarding)
module hazard_ctl_s23
    import hazard_ctl_s23_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_s2,
    input  logic [31:0] instr_s3,
    input  logic        rb_wr_s3,
    input  logic        pc_sel_s3,
    input  logic        dm_access_s3,
    input  logic        dm_ack,
    output logic        stall_out,
    output logic        hold_s23,
    output logic        bubble_s23,
    output logic        flush_s12,
    output logic        fwd1_sel,
    output logic        fwd2_sel,
    output logic        dm_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);
    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       flush_pend;
    logic       timeout_hit;
    logic       unused_instr;
    assign unused_instr = ^{instr_s2[31:25], instr_s2[14:0], instr_s3[31:12], instr_s3[6:0]};
    always_comb begin
        state_nxt   = state;
        stall_out   = 1'b0;
        bubble_s23  = 1'b0;
        flush_s12   = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            INIT: begin
                bubble_s23 = 1'b1;
                flush_s12  = 1'b1;
                state_nxt  = RUN;
            end
            RUN: begin
                if (dm_access_s3 && !dm_ack) begin
                    stall_out = 1'b1;
                    state_nxt = MEM_WAIT;
                end else begin
                    flush_s12  = pc_sel_s3;
                    bubble_s23 = pc_sel_s3;
                end
            end
            MEM_WAIT: begin
                // a branch that arrived during the stall is released together with it
                if (dm_ack || wait_cnt == 8'(TIMEOUT - 1)) begin
                    timeout_hit = !dm_ack;
                    flush_s12   = pc_sel_s3 | flush_pend;
                    bubble_s23  = pc_sel_s3 | flush_pend;
                    state_nxt   = RUN;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: state_nxt = INIT;
        endcase
    end
    assign hold_s23 = stall_out;
    assign fwd1_sel = state != INIT && rb_wr_s3 && rd_of(instr_s3) != 5'd0 && rd_of(instr_s3) == rs1_of(instr_s2);
    assign fwd2_sel = state != INIT && rb_wr_s3 && rd_of(instr_s3) != 5'd0 && rd_of(instr_s3) == rs2_of(instr_s2);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= INIT;
            wait_cnt   <= '0;
            dm_timeout <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= (state == MEM_WAIT && state_nxt == MEM_WAIT) ? wait_cnt + 8'd1 : 8'd0;
            dm_timeout <= dm_timeout | timeout_hit;
            flush_pend <= (state_nxt == MEM_WAIT) & (flush_pend | pc_sel_s3);
        end
    sat_cnt16 u_stall_cnt (.clk(clk), .clr_n(rst_n), .en(stall_out), .cnt(stall_cnt));
    sat_cnt16 u_flush_cnt (.clk(clk), .clr_n(rst_n), .en(flush_s12 && state != INIT), .cnt(flush_cnt));
endmodule

// File: tb/tb_hazard_ctl_s23.sv
// tb_hazard_ctl_s23: directed vector table, timeout/reset sequences and randomized model check
module tb_hazard_ctl_s23;
    localparam int TMO = 4;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] instr_s2 = '0, instr_s3 = '0;
    logic        rb_wr_s3 = 1'b0, pc_sel_s3 = 1'b0, dm_access_s3 = 1'b0, dm_ack = 1'b0;
    logic        stall_out, hold_s23, bubble_s23, flush_s12, fwd1_sel, fwd2_sel, dm_timeout;
    logic [15:0] stall_cnt, flush_cnt;
    int          tests = 0, fails = 0;
    always #5 clk = ~clk;
    hazard_ctl_s23 #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .instr_s2(instr_s2), .instr_s3(instr_s3),
        .rb_wr_s3(rb_wr_s3), .pc_sel_s3(pc_sel_s3), .dm_access_s3(dm_access_s3), .dm_ack(dm_ack),
        .stall_out(stall_out), .hold_s23(hold_s23), .bubble_s23(bubble_s23), .flush_s12(flush_s12),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .dm_timeout(dm_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
    // expected-output vector order: {stall, hold, bubble, flush, fwd1, fwd2, timeout}
    typedef struct {
        logic        rst, acc, ack, pc, rbw;
        logic [31:0] s2, s3;
        logic [6:0]  e;
        logic [15:0] sc, fc;
    } vec_t;
    vec_t tbl[$];
    function automatic logic [31:0] mk(int rs1, int rs2, int rd);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction
    function automatic void add(logic rst, logic acc, logic ack, logic pc, logic rbw,
                                logic [31:0] s2, logic [31:0] s3, logic [6:0] e, int sc, int fc);
        vec_t v;
        v = '{rst, acc, ack, pc, rbw, s2, s3, e, 16'(sc), 16'(fc)};
        tbl.push_back(v);
    endfunction
    function automatic logic [6:0] outs();
        return {stall_out, hold_s23, bubble_s23, flush_s12, fwd1_sel, fwd2_sel, dm_timeout};
    endfunction
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic drive(logic rst, logic acc, logic ack, logic pc, logic rbw, logic [31:0] s2, logic [31:0] s3);
        @(posedge clk);
        #1;
        rst_n = rst; dm_access_s3 = acc; dm_ack = ack; pc_sel_s3 = pc; rb_wr_s3 = rbw;
        instr_s2 = s2; instr_s3 = s3;
        @(negedge clk);
    endtask
    // reference model: counts stall cycles of the outstanding access, at most TMO of them
    int   m_started, m_waited, m_pend, m_tmo, m_sc, m_fc;
    task automatic model_cycle(string nm);
        logic st, bu, fl, f1, f2;
        logic [4:0] rd;
        st = 0; bu = 0; fl = 0;
        if (!m_started) begin
            bu = 1; fl = 1;
        end else if (m_waited == 0) begin
            if (dm_access_s3 && !dm_ack) st = 1;
            else begin fl = pc_sel_s3; bu = pc_sel_s3; end
        end else if (dm_ack || m_waited == TMO) begin
            fl = pc_sel_s3 | m_pend[0]; bu = fl;
        end else st = 1;
        rd = instr_s3[11:7];
        f1 = m_started != 0 && rb_wr_s3 && rd != 0 && rd == instr_s2[19:15];
        f2 = m_started != 0 && rb_wr_s3 && rd != 0 && rd == instr_s2[24:20];
        chk({nm, "_outs"}, 32'(outs()), 32'({st, st, bu, fl, f1, f2, m_tmo[0]}));
        chk({nm, "_scnt"}, 32'(stall_cnt), 32'(m_sc));
        chk({nm, "_fcnt"}, 32'(flush_cnt), 32'(m_fc));
        if (st && m_sc < 65535) m_sc++;
        if (fl && m_started != 0 && m_fc < 65535) m_fc++;
        if (!m_started) m_started = 1;
        else if (m_waited == 0) begin
            if (dm_access_s3 && !dm_ack) begin m_waited = 1; m_pend = pc_sel_s3; end
        end else if (dm_ack || m_waited == TMO) begin
            if (!dm_ack) m_tmo = 1;
            m_waited = 0; m_pend = 0;
        end else begin
            m_waited++; m_pend |= pc_sel_s3;
        end
    endtask
    initial begin
        add(0, 0, 0, 0, 0, 0, 0, 7'b0011000, 0, 0);
        add(1, 0, 0, 0, 1, mk(5, 0, 0), mk(0, 0, 5), 7'b0011000, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 7'b1100000, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 7'b1100000, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 7'b1100000, 2, 0);
        add(1, 1, 1, 0, 0, 0, 0, 7'b0000000, 3, 0);
        add(1, 0, 0, 0, 0, 0, 0, 7'b0000000, 3, 0);
        add(1, 0, 0, 1, 0, 0, 0, 7'b0011000, 3, 0);
        add(1, 0, 0, 0, 0, 0, 0, 7'b0000000, 3, 1);
        add(1, 1, 0, 1, 0, 0, 0, 7'b1100000, 3, 1);
        add(1, 1, 0, 1, 0, 0, 0, 7'b1100000, 4, 1);
        add(1, 1, 1, 1, 0, 0, 0, 7'b0011000, 5, 1);
        add(1, 0, 0, 0, 0, 0, 0, 7'b0000000, 5, 2);
        add(1, 0, 0, 0, 1, mk(5, 0, 0), mk(0, 0, 5), 7'b0000100, 5, 2);
        add(1, 0, 0, 0, 1, mk(0, 0, 0), mk(0, 0, 0), 7'b0000000, 5, 2);
        add(1, 0, 0, 0, 0, mk(5, 0, 0), mk(0, 0, 5), 7'b0000000, 5, 2);
        add(1, 0, 0, 0, 1, mk(3, 7, 0), mk(0, 0, 7), 7'b0000010, 5, 2);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].acc, tbl[i].ack, tbl[i].pc, tbl[i].rbw, tbl[i].s2, tbl[i].s3);
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].e));
            chk($sformatf("vec%0d_scnt", i), 32'(stall_cnt), 32'(tbl[i].sc));
            chk($sformatf("vec%0d_fcnt", i), 32'(flush_cnt), 32'(tbl[i].fc));
        end
        for (int c = 0; c < 5; c++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            chk($sformatf("tmo_c%0d_stall", c), 32'(stall_out), (c < 4) ? 32'd1 : 32'd0);
            chk($sformatf("tmo_c%0d_flag", c), 32'(dm_timeout), 32'd0);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("tmo_run_outs", 32'(outs()), 32'b0000001);
        chk("tmo_scnt", 32'(stall_cnt), 32'd9);
        drive(1, 1, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("tmo_sticky", 32'(dm_timeout), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("tmo_async_clr", 32'(outs()), 32'b0011000);
        chk("rst_scnt", 32'(stall_cnt), 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("midwait_stall", 32'(stall_out), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("midwait_rst_outs", 32'(outs()), 32'b0011000);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("midwait_no_tmo", 32'(dm_timeout), 32'd0);
        m_started = 0; m_waited = 0; m_pend = 0; m_tmo = 0; m_sc = 0; m_fc = 0;
        for (int n = 0; n < 3000; n++) begin
            drive(1, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                  1'($urandom), mk($urandom_range(0, 3), $urandom_range(0, 3), 0),
                  mk(0, 0, $urandom_range(0, 3)));
            model_cycle($sformatf("rnd%0d", n));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
